mem_stage_dm: RTL and testbench

//  MEM-stage data memory for the 5-stage MIPS pipeline, directly upstream of the MEM/WB register.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/dm_load_ext.sv | 40 ++++
 rtl/mem_stage_dm.sv | 108 ++++++++++
 tb/tb_mem_stage_dm.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-op encoding, data-memory defaults, lane helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mips_pkg;

  localparam int MEMOP_W = 3;

  localparam logic [MEMOP_W-1:0] MEMOP_WORD  = 3'b000;
  localparam logic [MEMOP_W-1:0] MEMOP_HALFU = 3'b001;
  localparam logic [MEMOP_W-1:0] MEMOP_HALFS = 3'b010;
  localparam logic [MEMOP_W-1:0] MEMOP_BYTEU = 3'b011;
  localparam logic [MEMOP_W-1:0] MEMOP_BYTES = 3'b100;

  localparam int          DM_DEPTH_WORDS = 3072;
  localparam logic [31:0] DM_ADDR_BASE   = 32'h0000_0000;

  function automatic logic memop_is_half(input logic [MEMOP_W-1:0] op);
    return (op == MEMOP_HALFU) || (op == MEMOP_HALFS);
  endfunction

  function automatic logic memop_is_byte(input logic [MEMOP_W-1:0] op);
    return (op == MEMOP_BYTEU) || (op == MEMOP_BYTES);
  endfunction

  // Reserved encodings fall through to word, so "word" is simply "not half, not byte".
  function automatic logic memop_is_word(input logic [MEMOP_W-1:0] op);
    return !memop_is_half(op) && !memop_is_byte(op);
  endfunction

  function automatic logic memop_is_signed(input logic [MEMOP_W-1:0] op);
    return (op == MEMOP_HALFS) || (op == MEMOP_BYTES);
  endfunction

  function automatic logic [3:0] memop_byte_en(input logic [MEMOP_W-1:0] op,
                                               input logic [1:0]         bo);
    logic [3:0] be;
    be = 4'b1111;
    if (memop_is_half(op)) begin
      be = bo[1] ? 4'b1100 : 4'b0011;
    end else if (memop_is_byte(op)) begin
      be = 4'b0001 << bo;
    end
    return be;
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] memop_lane_data(input logic [MEMOP_W-1:0] op,
                                                  input logic [31:0]        wd);
    logic [31:0] ld;
    ld = wd;
    if (memop_is_half(op)) begin
      ld = {wd[15:0], wd[15:0]};
    end else if (memop_is_byte(op)) begin
      ld = {4{wd[7:0]}};
    end
    return ld;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load aligner: picks the half/byte lane of a memory word and sign- or zero-extends it.
// Latency: 0 cycles (combinational).
// Backpressure: none.
module dm_load_ext
  import mips_pkg::*;
(
  input  logic [31:0]        word,
  input  logic [1:0]         bo,
  input  logic [MEMOP_W-1:0] memop,
  output logic [31:0]        rd
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic        sgn;

  always_comb begin
    half_lane = bo[1] ? word[31:16] : word[15:0];
    byte_lane = word[7:0];
    case (bo)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
  end

  assign sgn = memop_is_signed(memop);

  always_comb begin
    rd = word;
    if (memop_is_half(memop)) begin
      rd = {{16{sgn & half_lane[15]}}, half_lane};
    end else if (memop_is_byte(memop)) begin
      rd = {{24{sgn & byte_lane[7]}}, byte_lane};
    end
  end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: byte/half/word stores on clk, combinational aligned loads, address-error flag.
// Latency: load 0 cycles, store visible next cycle. Optional store trace under DM_TRACE_EN.
// Backpressure: none; a flagged (AdErrM) or reset-cycle store is dropped.
module mem_stage_dm
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = mips_pkg::DM_DEPTH_WORDS,
  parameter logic [31:0] ADDR_BASE   = mips_pkg::DM_ADDR_BASE
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         PCM,
  input  logic [31:0]         AddrM,
  input  logic [31:0]         WDM,
  input  logic                MemWriteM,
  input  logic [MEMOP_W-1:0]  MemOpM,
  output logic [31:0]         RDM,
  output logic                AdErrM
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [29:0]   idx;
  logic [1:0]    bo;
  logic          in_range;
  logic [AW-1:0] idx_s;
  logic          misaligned;
  logic          is_load;
  logic          ad_err;
  logic [31:0]   old_word;
  logic [31:0]   ext_word;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic [31:0]   merged;
  logic          commit;

  assign off = AddrM - ADDR_BASE;
  assign idx = off[31:2];
  assign bo  = off[1:0];

  // The base comparison catches AddrM below ADDR_BASE, where off wraps to a huge value.
  assign in_range = (AddrM >= ADDR_BASE) && ({2'b00, idx} < 32'(DEPTH_WORDS));
  assign idx_s    = in_range ? idx[AW-1:0] : '0;

  always_comb begin
    misaligned = 1'b0;
    if (memop_is_word(MemOpM)) begin
      misaligned = (bo != 2'b00);
    end else if (memop_is_half(MemOpM)) begin
      misaligned = bo[0];
    end
  end

  assign is_load = ~MemWriteM;
  assign ad_err  = (misaligned | ~in_range) & (MemWriteM | is_load);
  assign AdErrM  = ad_err;

  assign old_word = mem[idx_s];

  dm_load_ext u_load_ext (
    .word  (old_word),
    .bo    (bo),
    .memop (MemOpM),
    .rd    (ext_word)
  );

  assign RDM = ad_err ? 32'h0 : ext_word;

  assign be        = memop_byte_en(MemOpM, bo);
  assign lane_data = memop_lane_data(MemOpM, WDM);

  always_comb begin
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        merged[b*8 +: 8] = lane_data[b*8 +: 8];
      end
    end
  end

  assign commit = MemWriteM & ~reset & ~ad_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[idx_s] <= merged;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (commit) begin
      $display("@%h: *%h <= %h", PCM, {AddrM[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pcm;
  assign unused_pcm = ^PCM;
`endif

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed bench for mem_stage_dm with a queue scoreboard and immediate-assertion checks.
module tb_mem_stage_dm;

  logic        clk;
  logic        reset;
  logic [31:0] PCM;
  logic [31:0] AddrM;
  logic [31:0] WDM;
  logic        MemWriteM;
  logic [2:0]  MemOpM;
  logic [31:0] RDM;
  logic        AdErrM;

  int errors;
  int checks;

  logic [31:0] exp_rd_q [$];
  logic        exp_err_q[$];
  string       tag_q    [$];

  localparam logic [2:0] OP_W   = 3'b000;
  localparam logic [2:0] OP_HU  = 3'b001;
  localparam logic [2:0] OP_HS  = 3'b010;
  localparam logic [2:0] OP_BU  = 3'b011;
  localparam logic [2:0] OP_BS  = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b111;

  mem_stage_dm dut (
    .clk       (clk),
    .reset     (reset),
    .PCM       (PCM),
    .AddrM     (AddrM),
    .WDM       (WDM),
    .MemWriteM (MemWriteM),
    .MemOpM    (MemOpM),
    .RDM       (RDM),
    .AdErrM    (AdErrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [31:0] rd, input logic err);
    exp_rd_q.push_back(rd);
    exp_err_q.push_back(err);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    logic [31:0] e_rd;
    logic        e_err;
    string       t;
    e_rd  = exp_rd_q.pop_front();
    e_err = exp_err_q.pop_front();
    t     = tag_q.pop_front();
    checks++;
    assert (RDM === e_rd) else begin
      errors++;
      $error("FAIL %s RDM observed=%h expected=%h", t, RDM, e_rd);
    end
    checks++;
    assert (AdErrM === e_err) else begin
      errors++;
      $error("FAIL %s AdErrM observed=%b expected=%b", t, AdErrM, e_err);
    end
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] op,
                      input logic [31:0] erd, input logic eerr);
    PCM       = PCM + 32'd4;
    MemWriteM = 1'b0;
    AddrM     = a;
    MemOpM    = op;
    WDM       = 32'h0;
    expect_out(tag, erd, eerr);
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
  endtask

  // erd is the load view during the store cycle: old contents of the addressed word.
  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] op, input logic [31:0] erd, input logic eerr,
                       input logic rst);
    PCM       = PCM + 32'd4;
    reset     = rst;
    MemWriteM = 1'b1;
    AddrM     = a;
    MemOpM    = op;
    WDM       = d;
    expect_out(tag, erd, eerr);
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    PCM       = 32'h0040_0000;
    AddrM     = 32'h0;
    WDM       = 32'h0;
    MemWriteM = 1'b0;
    MemOpM    = OP_W;
    @(posedge clk);
    #1;
    reset = 1'b0;

    load("rst_lw_0",     32'h0000_0000, OP_W, 32'h0, 1'b0);
    load("rst_lw_top",   32'h0000_2FFC, OP_W, 32'h0, 1'b0);

    store("sw_10",       32'h0000_0010, 32'h1234_5678, OP_W, 32'h0, 1'b0, 1'b0);
    load("lw_10",        32'h0000_0010, OP_W, 32'h1234_5678, 1'b0);

    store("sb_11",       32'h0000_0011, 32'hFFFF_FFAB, OP_BU, 32'h0000_0056, 1'b0, 1'b0);
    load("lw_10_sb",     32'h0000_0010, OP_W,  32'h1234_AB78, 1'b0);
    load("lb_11",        32'h0000_0011, OP_BS, 32'hFFFF_FFAB, 1'b0);
    load("lbu_11",       32'h0000_0011, OP_BU, 32'h0000_00AB, 1'b0);

    store("sh_12",       32'h0000_0012, 32'h7777_8001, OP_HU, 32'h0000_1234, 1'b0, 1'b0);
    load("lw_10_sh",     32'h0000_0010, OP_W,  32'h8001_AB78, 1'b0);
    load("lh_12",        32'h0000_0012, OP_HS, 32'hFFFF_8001, 1'b0);
    load("lhu_12",       32'h0000_0012, OP_HU, 32'h0000_8001, 1'b0);
    load("lh_10",        32'h0000_0010, OP_HS, 32'hFFFF_AB78, 1'b0);
    load("lb_13",        32'h0000_0013, OP_BS, 32'hFFFF_FF80, 1'b0);
    load("lb_10",        32'h0000_0010, OP_BS, 32'h0000_0078, 1'b0);
    load("lw_rsv_op",    32'h0000_0010, OP_RSV, 32'h8001_AB78, 1'b0);

    store("sw_13_mis",   32'h0000_0013, 32'hDEAD_BEEF, OP_W, 32'h0, 1'b1, 1'b0);
    store("sw_3000_oor", 32'h0000_3000, 32'hDEAD_BEEF, OP_W, 32'h0, 1'b1, 1'b0);
    store("sh_11_mis",   32'h0000_0011, 32'hDEAD_BEEF, OP_HU, 32'h0, 1'b1, 1'b0);
    load("lw_10_kept",   32'h0000_0010, OP_W, 32'h8001_AB78, 1'b0);
    load("lw_3000",      32'h0000_3000, OP_W, 32'h0, 1'b1);
    load("lw_12_mis",    32'h0000_0012, OP_W, 32'h0, 1'b1);
    load("lhu_13_mis",   32'h0000_0013, OP_HU, 32'h0, 1'b1);
    load("lbu_3000_oor", 32'h0000_3000, OP_BU, 32'h0, 1'b1);
    load("lw_wrap_oor",  32'hFFFF_FFFC, OP_W, 32'h0, 1'b1);

    store("sb_2fff",     32'h0000_2FFF, 32'h0000_00C3, OP_BS, 32'h0, 1'b0, 1'b0);
    load("lw_2ffc",      32'h0000_2FFC, OP_W,  32'hC300_0000, 1'b0);
    load("lbu_2fff",     32'h0000_2FFF, OP_BU, 32'h0000_00C3, 1'b0);
    load("lb_2fff",      32'h0000_2FFF, OP_BS, 32'hFFFF_FFC3, 1'b0);

    store("sw_20_rst",   32'h0000_0020, 32'h0000_0055, OP_W, 32'h0, 1'b0, 1'b1);
    load("lw_20_dropped", 32'h0000_0020, OP_W, 32'h0, 1'b0);
    load("lw_10_cleared", 32'h0000_0010, OP_W, 32'h0, 1'b0);
    load("lw_2ffc_cleared", 32'h0000_2FFC, OP_W, 32'h0, 1'b0);

    store("sw_20_after", 32'h0000_0020, 32'hCAFE_F00D, OP_W, 32'h0, 1'b0, 1'b0);
    load("lw_20_after",  32'h0000_0020, OP_W, 32'hCAFE_F00D, 1'b0);

    checks++;
    assert (exp_rd_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_rd_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
